// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel kernel.
// Window indices are row-major with D4 as the centre pixel.
package sobel_pkg;

  localparam int D0 = 0;
  localparam int D1 = 1;
  localparam int D2 = 2;
  localparam int D3 = 3;
  localparam int D4 = 4;
  localparam int D5 = 5;
  localparam int D6 = 6;
  localparam int D7 = 7;
  localparam int D8 = 8;

  localparam int PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  // |gx| + |gy| clamped to max_v
  function automatic int unsigned sat_mag(
    input int          gx,
    input int          gy,
    input int unsigned max_v
  );
    int unsigned ax;
    int unsigned ay;
    int unsigned sum;
    ax  = unsigned'(gx < 0 ? -gx : gx);
    ay  = unsigned'(gy < 0 ? -gy : gy);
    sum = ax + ay;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/sobel_line_window.sv
// Two line-length shift memories feeding a 3x3 window.
// After a shift, win[D8] holds the newest pixel.
module sobel_line_window
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] win [9],
  output logic             win_valid
);

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];

  // line buffers: lb0 delays by one row, lb1 by two
  always_ff @(posedge clk) begin
    if (shift_en) begin
      lb0[0] <= pix_in;
      lb1[0] <= lb0[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        lb0[i] <= lb0[i-1];
        lb1[i] <= lb1[i-1];
      end
    end
  end

  // window rows: bottom from input, middle/top from line buffers
  always_ff @(posedge clk) begin
    if (shift_en) begin
      win[D8] <= pix_in;
      win[D7] <= win[D8];
      win[D6] <= win[D7];
      win[D5] <= lb0[IMG_W-1];
      win[D4] <= win[D5];
      win[D3] <= win[D4];
      win[D2] <= lb1[IMG_W-1];
      win[D1] <= win[D2];
      win[D0] <= win[D1];
    end
  end

  // strobe marking a freshly shifted window
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_valid <= 1'b0;
    end else begin
      win_valid <= shift_en;
    end
  end

endmodule

// File: rtl/sobel_stream_kernel.sv
// Streaming 3x3 Sobel magnitude kernel with border zeroing and tail flush.
// Define SOBEL_THRESH_EN to binarise the magnitude against thresh_i.
module sobel_stream_kernel
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [PIX_W-1:0] pixel_i,
  input  logic             done_i,
  input  logic [PIX_W-1:0] thresh_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [PIX_W-1:0] pixel_o,
  output logic             done_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 3;
  localparam int unsigned MAG_MAX = (1 << PIX_W) - 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [RW-1:0] R_ONE = RW'(1);

  state_t state;
  state_t state_nx;

  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          short_q;

  logic acc;
  logic flushing;
  logic iss;
  logic last_c;
  logic fill_done;
  logic border_c;

  logic [PIX_W-1:0] win [9];
  logic             win_valid;
  logic             unused_centre;

  logic             s0_v, s0_b, s0_last;
  logic             v1, b1, last1;
  logic signed [GW-1:0] gx_c, gy_c;
  logic signed [GW-1:0] gx_q, gy_q;
  logic [PIX_W-1:0] mag;
  logic [PIX_W-1:0] pix_c;

  function automatic logic signed [GW-1:0] ext(
    input logic [PIX_W-1:0] v
  );
    return $signed({3'b000, v});
  endfunction

  assign ready_o   = (state != FLUSH);
  assign acc       = valid_i & ready_o;
  assign flushing  = (state == FLUSH);
  assign iss       = ((state == RUN) & acc) | flushing;
  assign last_c    = (out_row == ROW_LAST) && (out_col == COL_LAST);
  assign fill_done = (in_row == R_ONE) && (in_col == '0);
  assign border_c  = (out_row == '0) || (out_row == ROW_LAST) ||
                     (out_col == '0) || (out_col == COL_LAST);
  assign unused_centre = ^win[D4];

  sobel_line_window #(
    .IMG_W(IMG_W),
    .PIX_W(PIX_W)
  ) u_win (
    .clk      (clk),
    .rst      (rst),
    .shift_en (acc | flushing),
    .pix_in   (flushing ? '0 : pixel_i),
    .win      (win),
    .win_valid(win_valid)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state: short frames jump straight to FLUSH
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (acc) state_nx = done_i ? FLUSH : FILL;
      end
      FILL: begin
        if (acc && done_i)    state_nx = FLUSH;
        else if (acc && fill_done) state_nx = RUN;
      end
      RUN: begin
        if (acc && done_i) state_nx = FLUSH;
      end
      FLUSH: begin
        if (last_c) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // input/output raster counters and short-frame flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_col  <= '0;
      in_row  <= '0;
      out_col <= '0;
      out_row <= '0;
      short_q <= 1'b0;
    end else begin
      if (acc) begin
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? '0 : in_row + R_ONE;
        end else begin
          in_col <= in_col + C_ONE;
        end
      end
      if (iss) begin
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == ROW_LAST) ? '0 : out_row + R_ONE;
        end else begin
          out_col <= out_col + C_ONE;
        end
      end
      if (acc && done_i && (state == IDLE || state == FILL)) begin
        short_q <= 1'b1;
      end
      if (flushing && last_c) begin
        in_col  <= '0;
        in_row  <= '0;
        short_q <= 1'b0;
      end
    end
  end

  // tags travelling alongside the window registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_v    <= 1'b0;
      s0_b    <= 1'b0;
      s0_last <= 1'b0;
    end else begin
      s0_v    <= iss;
      s0_b    <= border_c | short_q;
      s0_last <= flushing & last_c;
    end
  end

  // raw Sobel gradients from the current window
  always_comb begin
    gx_c = (ext(win[D2]) + (ext(win[D5]) <<< 1) + ext(win[D8])) -
           (ext(win[D0]) + (ext(win[D3]) <<< 1) + ext(win[D6]));
    gy_c = (ext(win[D6]) + (ext(win[D7]) <<< 1) + ext(win[D8])) -
           (ext(win[D0]) + (ext(win[D1]) <<< 1) + ext(win[D2]));
  end

  // stage 1: register gradients, zero for border centres
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1    <= 1'b0;
      b1    <= 1'b0;
      last1 <= 1'b0;
      gx_q  <= '0;
      gy_q  <= '0;
    end else begin
      v1    <= s0_v & win_valid;
      b1    <= s0_b;
      last1 <= s0_last;
      gx_q  <= s0_b ? '0 : gx_c;
      gy_q  <= s0_b ? '0 : gy_c;
    end
  end

  // magnitude, optional binarisation and border forcing
  always_comb begin
    mag = PIX_W'(sat_mag(int'(gx_q), int'(gy_q), MAG_MAX));
`ifdef SOBEL_THRESH_EN
    pix_c = (mag >= thresh_i) ? '1 : '0;
`else
    pix_c = mag;
`endif
    if (b1) pix_c = '0;
  end

`ifndef SOBEL_THRESH_EN
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;
`endif

  // stage 2: output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_o <= 1'b0;
      pixel_o <= '0;
      done_o  <= 1'b0;
    end else begin
      valid_o <= v1;
      pixel_o <= v1 ? pix_c : '0;
      done_o  <= v1 & last1;
    end
  end

endmodule

// File: doc/sobel_stream_kernel.md
Name: sobel_stream_kernel

Overview:
Parametrised streaming Sobel edge kernel: next generation of the fixed 8-bit grayscale Sobel kernel.
- Accepts one raster-order pixel per valid beat.
- Builds the 3x3 window internally from two line buffers.
- Emits one gradient-magnitude pixel per input pixel, zeroing frame borders.
- Flushes the tail after done_i, so each frame yields exactly IMG_W*IMG_H outputs.
- Sits between the grayscale converter and the frame writer.

Parameters:
IMG_W, 640, frame width in pixels (>=4)
IMG_H, 480, frame height in pixels (>=3)
PIX_W, 8, pixel bit width, input and output

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous to clk, active-low
valid_i  input  1  pixel_i valid this cycle
pixel_i  input  PIX_W  grayscale input pixel, raster order
done_i  input  1  one-cycle pulse coincident with the frame's last valid_i beat
thresh_i  input  PIX_W  binarisation threshold (used only with SOBEL_THRESH_EN)
ready_o  output  1  kernel accepts input; low during FLUSH
valid_o  output  1  pixel_o valid this cycle
pixel_o  output  PIX_W  gradient magnitude
done_o  output  1  one-cycle pulse coincident with the frame's last valid_o beat

Behaviour:
- Reset: synchronous, active-low, one clock, synchronous to clk.
  - rst=0 at a clk edge forces: valid_o=0, pixel_o=0, done_o=0, ready_o=1, state=IDLE, counters=0.
  - Line-buffer contents are not cleared.
  - Reset mid-frame abandons the frame; no partial done_o.
- Accept: a beat is accepted when valid_i & ready_o. A valid_i beat while ready_o=0 is dropped.
- Counters: in_col/in_row track accepted pixels; out_col/out_row track the emitted centre pixel; all wrap at IMG_W/IMG_H.
- Window: d0..d8 row-major, d4 = centre.
  - Line buffers are two IMG_W x PIX_W shift memories.
  - Centre pixel n becomes computable when input n+IMG_W+1 is accepted.
- Pipeline: 2 register stages.
  - Stage 1: Gx = (d2+2*d5+d8)-(d0+2*d3+d6) and Gy = (d6+2*d7+d8)-(d0+2*d1+d2), signed PIX_W+3 bits.
  - Stage 2: mag = |Gx|+|Gy|, saturated to 2^PIX_W-1.
- Border: if out_row is 0 or IMG_H-1, or out_col is 0 or IMG_W-1, pixel_o=0; the gradient is not computed for these.
- Latency: valid_o for centre n asserts exactly 2 cycles after input n+IMG_W+1 is accepted. Input gaps propagate as output gaps; no output-side backpressure.
- FSM:
  - IDLE: first accepted beat -> FILL.
  - FILL: counts IMG_W+1 accepted beats, no output; then -> RUN.
  - RUN: one output per accepted beat; accepted beat with done_i=1 -> FLUSH.
  - FLUSH: ready_o=0; emits remaining IMG_W+1 centres, one per cycle, back-to-back, using zero-filled synthetic input; the last of these sets done_o; -> IDLE.
- done_o: asserted with the (IMG_W*IMG_H)-th valid_o of the frame only.
- Edge cases:
  - done_i while in FILL (frame shorter than IMG_W+2) -> go to FLUSH, emitting zeros until IMG_W*IMG_H outputs total.
  - done_i without valid_i is ignored.
  - valid_i in FLUSH is dropped; the next frame may start one cycle after the flush ends.

Optional Feature:
SOBEL_THRESH_EN
- Defined: an extra compare after stage 2, in the same cycle (latency unchanged). pixel_o = (mag >= thresh_i) ? 2^PIX_W-1 : 0; border pixels stay 0.
- Undefined: thresh_i is ignored and pixel_o = saturated magnitude.

Decomposition:
- Package sobel_pkg: window-index constants (D0..D8), state enum (IDLE, FILL, RUN, FLUSH), PIPE_LAT=2, and a saturating-magnitude helper function.
- Sub-module sobel_line_window: line buffers plus 3x3 window registers, producing d0..d8 and a window-valid strobe.
- Gradient arithmetic, FSM and counters stay in the top.

Test Plan:
- 8x8 frame, all pixels 100, continuous valid_i -> 64 valid_o beats, all pixel_o=0; single done_o on beat 64.
- 8x8 frame, columns 0-3 = 0 and columns 4-7 = 255 -> interior rows (1-6): pixel_o=255 at cols 3 and 4, 0 elsewhere; border rows/cols = 0.
- Latency: first accepted pixel at cycle T -> first valid_o at T+IMG_W+1+2 = T+11 for IMG_W=8; during FLUSH, ready_o=0 for exactly 9 cycles.
- valid_i toggling every other cycle on the 8x8 vertical-edge image -> identical output values and order; output gaps mirror input gaps.
- Reset (rst=0) held one cycle at pixel 30 -> valid_o=0 and done_o=0 next cycle; a fresh 8x8 frame then produces correct 64 outputs.
- SOBEL_THRESH_EN defined, thresh_i=128, image with one interior pixel 40 among zeros -> pixel_o=0 at that pixel's four orthogonal neighbours (|G|=80); thresh_i=64 -> 255 at those four.
